clk_slice_monitor: RTL

CLK_SLICE_MONITOR -- requirements
Module: clk_slice_monitor

---
 rtl/clkmon_pkg.sv | 24 ++
 rtl/clkmon_decode.sv | 21 ++
 rtl/clk_slice_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clkmon_pkg.sv
// Shared definitions for the clock-enable slice monitor: state encoding,
// sync slot, strobe bit order and default lock length.
package clkmon_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [5:0] SYNC_SLOT = 6'd32;
  localparam int LOCK_CYCLES_DEF = 64;

  // Bit positions of each strobe inside the 7-bit strobe vector
  localparam int STB_CE12    = 0;
  localparam int STB_CE6     = 1;
  localparam int STB_CE3     = 2;
  localparam int STB_CE3V    = 3;
  localparam int STB_VIDEO   = 4;
  localparam int STB_CE1M5   = 5;
  localparam int STB_PIPE_AB = 6;
  localparam int STB_W       = 7;

endpackage

// File: rtl/clkmon_decode.sv
// Combinational map from a 6-bit slot counter value to the strobe pattern
// an ideal clock-enable generator would present in that slot.
module clkmon_decode
  import clkmon_pkg::*;
(
  input  logic [5:0]       slot,
  output logic [STB_W-1:0] strobes
);

  always_comb begin
    strobes = '0;
    strobes[STB_CE12]    = slot[0];
    strobes[STB_CE6]     = slot[1] & slot[0];
    strobes[STB_CE3]     = slot[2] & ~slot[1] & slot[0];
    strobes[STB_CE3V]    = slot[2] & slot[1] & ~slot[0];
    strobes[STB_VIDEO]   = ~slot[2];
    strobes[STB_CE1M5]   = slot[3] & slot[2] & ~slot[1] & slot[0];
    strobes[STB_PIPE_AB] = slot[5];
  end

endmodule

// File: rtl/clk_slice_monitor.sv
// Recovers the slot counter from observed clock-enable strobes and flags any
// deviation. Optional saturating error counter: define CLKMON_ERRCNT_EN.
module clk_slice_monitor
  import clkmon_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic       clk24,
  input  logic       reset,
  input  logic       ce12,
  input  logic       ce6,
  input  logic       ce3,
  input  logic       ce3v,
  input  logic       video_slice,
  input  logic       pipe_ab,
  input  logic       ce1m5,
  output logic       locked,
  output logic [5:0] phase,
  output logic       mismatch,
  output logic [7:0] err_count
);

  localparam logic [7:0] VCNT_LAST = 8'(LOCK_CYCLES - 2);

  state_t           state_reg, state_next;
  logic [5:0]       phase_reg, phase_next;
  logic [7:0]       vcnt_reg, vcnt_next;
  logic             locked_reg;
  logic             mismatch_reg, mismatch_next;
  logic             pab_q_reg;

  logic [STB_W-1:0] observed;
  logic [STB_W-1:0] exp_sync;
  logic [STB_W-1:0] exp_run;
  logic [5:0]       phase_inc;
  logic             rise;
  logic             sync_hit;
  logic             run_match;

  always_comb begin
    observed              = '0;
    observed[STB_CE12]    = ce12;
    observed[STB_CE6]     = ce6;
    observed[STB_CE3]     = ce3;
    observed[STB_CE3V]    = ce3v;
    observed[STB_VIDEO]   = video_slice;
    observed[STB_CE1M5]   = ce1m5;
    observed[STB_PIPE_AB] = pipe_ab;
  end

  assign phase_inc = phase_reg + 6'd1;

  clkmon_decode u_decode_sync (
    .slot    (SYNC_SLOT),
    .strobes (exp_sync)
  );

  clkmon_decode u_decode_run (
    .slot    (phase_inc),
    .strobes (exp_run)
  );

  // A rise implies pipe_ab=1, which the sync pattern also expects, so a full
  // vector compare is equivalent to checking only the other six strobes.
  assign rise      = pipe_ab & ~pab_q_reg;
  assign sync_hit  = rise && (observed == exp_sync);
  assign run_match = (observed == exp_run);

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    vcnt_next     = vcnt_reg;
    mismatch_next = 1'b0;
    case (state_reg)
      ST_HUNT: begin
        if (sync_hit) begin
          state_next = ST_VERIFY;
          phase_next = SYNC_SLOT;
          vcnt_next  = 8'd0;
        end
      end
      ST_VERIFY: begin
        if (!run_match) begin
          state_next    = ST_HUNT;
          phase_next    = 6'd0;
          vcnt_next     = 8'd0;
          mismatch_next = 1'b1;
        end else begin
          phase_next = phase_inc;
          vcnt_next  = vcnt_reg + 8'd1;
          if (vcnt_reg == VCNT_LAST) begin
            state_next = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (!run_match) begin
          state_next    = ST_HUNT;
          phase_next    = 6'd0;
          vcnt_next     = 8'd0;
          mismatch_next = 1'b1;
        end else begin
          phase_next = phase_inc;
        end
      end
      default: begin
        state_next = ST_HUNT;
        phase_next = 6'd0;
        vcnt_next  = 8'd0;
      end
    endcase
  end

  // pab_q resets high so a pipe_ab held through reset is not seen as a rise
  always_ff @(posedge clk24) begin
    if (reset) begin
      state_reg    <= ST_HUNT;
      phase_reg    <= 6'd0;
      vcnt_reg     <= 8'd0;
      locked_reg   <= 1'b0;
      mismatch_reg <= 1'b0;
      pab_q_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      vcnt_reg     <= vcnt_next;
      locked_reg   <= (state_next == ST_LOCKED);
      mismatch_reg <= mismatch_next;
      pab_q_reg    <= pipe_ab;
    end
  end

`ifdef CLKMON_ERRCNT_EN
  logic [7:0] err_reg;

  always_ff @(posedge clk24) begin
    if (reset) begin
      err_reg <= 8'd0;
    end else if (mismatch_next && (err_reg != 8'hFF)) begin
      err_reg <= err_reg + 8'd1;
    end
  end

  assign err_count = err_reg;
`else
  assign err_count = 8'd0;
`endif

  assign locked   = locked_reg;
  assign phase    = phase_reg;
  assign mismatch = mismatch_reg;

endmodule
